// File: rtl/nco_phase_gen_pkg.sv
// nco_phase_gen_pkg: shared widths, FSM states and constants for the NCO phase generator
package nco_phase_gen_pkg;
  localparam int NCO_ACC_W = 32;
  localparam int NCO_PHASE_W = 16;
  localparam int NCO_GLIDE_W = 4;
  typedef enum logic [1:0] {IDLE, LOAD, GLIDE} nco_state_t;
  localparam logic [NCO_ACC_W-1:0] FTW_ZERO = '0;
endpackage

// File: rtl/nco_phase_gen_glide_slew.sv
// nco_phase_gen_glide_slew: one portamento step of cur toward tgt, snapping when the shifted step is 0
module nco_phase_gen_glide_slew #(
  parameter int ACC_W = 32,
  parameter int GLIDE_W = 4
) (
  input  logic [ACC_W-1:0]   cur,
  input  logic [ACC_W-1:0]   tgt,
  input  logic [GLIDE_W-1:0] rate,
  output logic [ACC_W-1:0]   next_cur,
  output logic               done
);
  logic signed [ACC_W:0] diff, step;
  always_comb begin
    diff = $signed({1'b0, tgt}) - $signed({1'b0, cur});
    step = diff >>> rate;
    done = step == '0;
    next_cur = done ? tgt : cur + step[ACC_W-1:0];
  end
endmodule

// File: rtl/nco_phase_gen.sv
// nco_phase_gen: phase accumulator with FTW handshake, portamento glide and hard sync
module nco_phase_gen
  import nco_phase_gen_pkg::*;
#(
  parameter int ACC_W = NCO_ACC_W,
  parameter int PHASE_W = NCO_PHASE_W,
  parameter int GLIDE_W = NCO_GLIDE_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               sample_tick,
  input  logic [ACC_W-1:0]   ftw_in,
  input  logic               ftw_valid,
  output logic               ftw_ready,
  input  logic [GLIDE_W-1:0] glide_rate,
  input  logic               hard_sync,
  output logic [PHASE_W-1:0] phase_out,
  output logic               phase_valid,
  output logic               wrap
);
  nco_state_t state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d, cur_ftw_q, cur_ftw_d, tgt_ftw_q, tgt_ftw_d, glide_cur;
  logic [GLIDE_W-1:0] rate_q, rate_d;
  logic [PHASE_W-1:0] phase_q, phase_d;
  logic carry_q, carry_d, sync_pend_q, sync_pend_d, sync_now;
  logic tick_q, valid_q, wrap_q, glide_done, xfer;

  nco_phase_gen_glide_slew #(.ACC_W(ACC_W), .GLIDE_W(GLIDE_W)) u_slew (
    .cur(cur_ftw_q), .tgt(tgt_ftw_q), .rate(rate_q), .next_cur(glide_cur), .done(glide_done)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      acc_q <= FTW_ZERO;
      cur_ftw_q <= FTW_ZERO;
      tgt_ftw_q <= FTW_ZERO;
      rate_q <= '0;
      carry_q <= 1'b0;
      sync_pend_q <= 1'b0;
      tick_q <= 1'b0;
      valid_q <= 1'b0;
      wrap_q <= 1'b0;
      phase_q <= '0;
    end else begin
      state_q <= state_d;
      acc_q <= acc_d;
      cur_ftw_q <= cur_ftw_d;
      tgt_ftw_q <= tgt_ftw_d;
      rate_q <= rate_d;
      carry_q <= carry_d;
      sync_pend_q <= sync_pend_d;
      tick_q <= sample_tick;
      valid_q <= tick_q;
      wrap_q <= tick_q & carry_q;
      phase_q <= phase_d;
    end
  end

  assign xfer = ftw_valid & ftw_ready;

  // A retarget from GLIDE takes priority over that cycle's glide step
  always_comb begin
    state_d = state_q;
    cur_ftw_d = cur_ftw_q;
    tgt_ftw_d = tgt_ftw_q;
    rate_d = rate_q;
    case (state_q)
      IDLE, GLIDE: begin
        if (xfer) begin
          tgt_ftw_d = ftw_in;
          rate_d = glide_rate;
          state_d = LOAD;
        end else if (state_q == GLIDE && sample_tick) begin
          cur_ftw_d = glide_cur;
          state_d = glide_done ? IDLE : GLIDE;
        end
      end
      LOAD: begin
        cur_ftw_d = rate_q == '0 ? tgt_ftw_q : cur_ftw_q;
        state_d = rate_q == '0 ? IDLE : GLIDE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb ftw_ready = state_q != LOAD;

  // The tick adds the pre-update cur_ftw; a pending sync zeroes acc and suppresses the carry
  always_comb begin
    sync_now = sync_pend_q | hard_sync;
    {carry_d, acc_d} = !sample_tick ? {carry_q, acc_q} :
                       sync_now ? '0 : {1'b0, acc_q} + {1'b0, cur_ftw_q};
    sync_pend_d = !sample_tick & sync_now;
    phase_d = tick_q ? acc_q[ACC_W-1 -: PHASE_W] : phase_q;
  end

  assign phase_out = phase_q;
  assign phase_valid = valid_q;
  assign wrap = wrap_q;
endmodule
